fetch_pc_controller: RTL and testbench
======================================

// Module: fetch_pc_controller
// PURPOSE
//  Sequences the fetch stage of the pipelined RV32 core. Owns the program counter and issues
//  instruction-memory requests with a req/ready handshake. Applies hazard-unit stalls through a
//  1-entry skid buffer and redirects from branch/jump resolution. Drives the IF/ID register
//  inputs (if_valid, if_pc, if_instr) and sits between the imem port and the IF/ID pipeline register.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded on reset; must be word-aligned
//  NOP_INSTR     32'h0000_0013  if_instr value on reset (addi x0,x0,0)
// PORTS
//  clk               in   1   rising-edge clock
//  reset             in   1   asynchronous, active-low reset (0 = reset)
//  stall_i           in   1   hazard unit: hold IF/ID outputs
//  redirect_valid    in   1   branch/jump taken this cycle
//  redirect_target   in   32  new PC for redirect
//  imem_req          out  1   fetch request
//  imem_addr         out  32  fetch address; stable while imem_req=1 and imem_ready=0
//  imem_ready        in   1   imem_rdata valid this cycle; handshake = imem_req & imem_ready
//  imem_rdata        in   32  fetched instruction
//  if_valid          out  1   if_pc/if_instr hold a live instruction
//  if_pc             out  32  PC of the instruction presented
//  if_instr          out  32  instruction presented
//  pc_out            out  32  current fetch PC (debug/trace)
//  redirect_misalign out  1   1-cycle pulse: redirect_target[1:0] != 0
// BEHAVIOUR
//  Reset (reset=0, async): pc=RESET_VECTOR, state=BOOT, if_valid=0, if_pc=0, if_instr=NOP_INSTR,
//   skid empty, redirect_misalign=0, imem_req=0. An outstanding request is abandoned.
//  States: BOOT, FETCH, HOLD, DRAIN. All outputs are registered except imem_req/imem_addr (decoded from state).
//  BOOT: imem_req=0. Next cycle -> FETCH (first request 1 cycle after reset release).
//  FETCH: imem_req=1, imem_addr=pc. Handshake completes in the same cycle that ready is seen (0 extra latency).
//   complete & !stall_i: if_valid<=1, if_pc<=pc, if_instr<=imem_rdata, pc<=pc+4; stay FETCH.
//   complete & stall_i:  skid<={pc,imem_rdata}, pc<=pc+4, if_* held; -> HOLD.
//   !complete & !stall_i: if_valid<=0 (bubble). !complete & stall_i: if_* held.
//  HOLD: imem_req=0. stall_i=0: if_*<=skid, if_valid<=1, skid emptied; -> FETCH. stall_i=1: stay.
//  DRAIN: imem_req=1, imem_addr=drain_addr (address of the killed request). On imem_ready: rdata discarded;
//   -> FETCH. if_valid=0 throughout.
//  Redirect (redirect_valid=1) has priority over stall_i and any completion, in every state:
//   pc<={target[31:2],2'b00}; if_valid<=0; skid discarded; redirect_misalign<=|target[1:0].
//   FETCH & !imem_ready: drain_addr<=pc; -> DRAIN (request never withdrawn mid-handshake).
//   FETCH & imem_ready: beat discarded; stay FETCH. HOLD/BOOT -> FETCH. DRAIN: stay DRAIN, latest target wins.
//  PC arithmetic is 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
//  if_pc/if_instr retain their last values when if_valid=0; only if_valid qualifies them.
//  pc_out = pc register at all times.
// TESTING
//  1 Reset release, imem_ready=1 always -> BOOT 1 cycle; if_pc 0,4,8,C on consecutive cycles, if_valid=1.
//  2 Ready low 3 cycles at addr 0x8 -> imem_addr stays 0x8; if_valid=0 for those cycles; then if_pc=0x8.
//  3 stall_i=1 for 4 cycles while beat at 0xC completes -> if_* frozen, imem_req=0 in HOLD;
//    on release if_pc=0xC, next 0x10; no instruction lost or duplicated.
//  4 Redirect to 0x100 while ready=0 at 0x14 -> DRAIN holds addr 0x14 until ready; data dropped;
//    next request at 0x100; if_valid=0 until 0x100 returns.
//  5 Redirect to 0x203 during stall with skid full -> skid dropped, redirect_misalign 1 cycle, pc=0x200.
//  6 RESET_VECTOR=32'hFFFF_FFF8, ready=1 -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000;
//    reset asserted mid-DRAIN -> imem_req=0 immediately, pc=RESET_VECTOR.

Source files
------------

// File: rtl/fetch_pc_controller.sv
// fetch_pc_controller: RV32 fetch sequencer owning the PC, imem req/ready handshake,
// a 1-entry skid buffer for hazard stalls, and branch/jump redirect with request draining.
module fetch_pc_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] pc_out,
    output logic        redirect_misalign
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;
    state_t state, state_n;
    logic [31:0] pc, pc_n, if_pc_n, if_instr_n, skid_pc, skid_pc_n, skid_instr, skid_instr_n;
    logic [31:0] drain_addr, drain_addr_n;
    logic        if_valid_n, misalign_n;
    assign imem_req  = state == FETCH || state == DRAIN;
    assign imem_addr = state == DRAIN ? drain_addr : pc;
    assign pc_out    = pc;
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        if_valid_n   = if_valid;
        if_pc_n      = if_pc;
        if_instr_n   = if_instr;
        skid_pc_n    = skid_pc;
        skid_instr_n = skid_instr;
        drain_addr_n = drain_addr;
        misalign_n   = 1'b0;
        if (redirect_valid) begin
            pc_n       = {redirect_target[31:2], 2'b00};
            if_valid_n = 1'b0;
            misalign_n = |redirect_target[1:0];
            // an in-flight request cannot be withdrawn, so it is drained instead
            if (state == FETCH && !imem_ready) begin
                drain_addr_n = pc;
                state_n      = DRAIN;
            end else if (state != DRAIN) begin
                state_n = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready && !stall_i) begin
                        if_valid_n = 1'b1;
                        if_pc_n    = pc;
                        if_instr_n = imem_rdata;
                        pc_n       = pc + 32'd4;
                    end else if (imem_ready) begin
                        skid_pc_n    = pc;
                        skid_instr_n = imem_rdata;
                        pc_n         = pc + 32'd4;
                        state_n      = HOLD;
                    end else if (!stall_i) begin
                        if_valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        if_valid_n = 1'b1;
                        if_pc_n    = skid_pc;
                        if_instr_n = skid_instr;
                        state_n    = FETCH;
                    end
                end
                DRAIN: begin
                    if_valid_n = 1'b0;
                    state_n    = imem_ready ? FETCH : DRAIN;
                end
                default: state_n = FETCH;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= BOOT;
            pc                <= RESET_VECTOR;
            if_valid          <= 1'b0;
            if_pc             <= 32'h0;
            if_instr          <= NOP_INSTR;
            skid_pc           <= 32'h0;
            skid_instr        <= 32'h0;
            drain_addr        <= 32'h0;
            redirect_misalign <= 1'b0;
        end else begin
            state             <= state_n;
            pc                <= pc_n;
            if_valid          <= if_valid_n;
            if_pc             <= if_pc_n;
            if_instr          <= if_instr_n;
            skid_pc           <= skid_pc_n;
            skid_instr        <= skid_instr_n;
            drain_addr        <= drain_addr_n;
            redirect_misalign <= misalign_n;
        end
    end
endmodule

// File: tb/tb_fetch_pc_controller.sv
// tb_fetch_pc_controller: per-cycle vector table plus an in-order scoreboard of consumed
// instructions; a second instance covers PC wrap and reset during DRAIN.
module tb_fetch_pc_controller;
    localparam logic [31:0] K = 32'h1357_0000;
    logic        clk = 1'b0;
    logic        reset, stall, redir, ready;
    logic [31:0] target, rdata, addr, if_pc, if_instr, pc_out;
    logic        req, if_valid, mis;
    logic        reset2, redir2, ready2;
    logic [31:0] target2, rdata2, addr2, if_pc2, if_instr2, pc2;
    logic        req2, if_valid2, mis2;
    int          errors = 0, checks = 0;
    logic        mon_en = 1'b0;
    logic [31:0] sb[$];
    always #5 clk = ~clk;
    assign rdata  = addr ^ K;
    assign rdata2 = addr2 ^ K;
    fetch_pc_controller dut (
        .clk(clk), .reset(reset), .stall_i(stall), .redirect_valid(redir),
        .redirect_target(target), .imem_req(req), .imem_addr(addr), .imem_ready(ready),
        .imem_rdata(rdata), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .pc_out(pc_out), .redirect_misalign(mis)
    );
    fetch_pc_controller #(.RESET_VECTOR(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset2), .stall_i(1'b0), .redirect_valid(redir2),
        .redirect_target(target2), .imem_req(req2), .imem_addr(addr2), .imem_ready(ready2),
        .imem_rdata(rdata2), .if_valid(if_valid2), .if_pc(if_pc2), .if_instr(if_instr2),
        .pc_out(pc2), .redirect_misalign(mis2)
    );
    typedef struct {
        logic ready, stall, redir; logic [31:0] target;
        logic req; logic [31:0] addr; logic valid; logic [31:0] ifpc, pc; logic mis;
    } vec_t;
    vec_t v[26];
    function automatic vec_t mk(logic r, logic s, logic rd, logic [31:0] t, logic q,
                                logic [31:0] a, logic vl, logic [31:0] ip, logic [31:0] p, logic m);
        vec_t x;
        x.ready = r; x.stall = s; x.redir = rd; x.target = t; x.req = q; x.addr = a;
        x.valid = vl; x.ifpc = ip; x.pc = p; x.mis = m;
        return x;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // an instruction is consumed by decode when presented valid and not stalled
    always @(negedge clk) begin
        if (mon_en && if_valid && !stall) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underflow: got pc %h expected none", if_pc);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("sb_pc", if_pc, e);
                chk("sb_instr", if_instr, e ^ K);
            end
        end
    end
    initial begin
        //          rdy stl rd  target        req addr          vld if_pc         pc            mis
        v[0]  = mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,   0);
        v[1]  = mk(1, 0, 0, 32'h0,   1, 32'h0,   1, 32'h0,   32'h4,   0);
        v[2]  = mk(1, 0, 0, 32'h0,   1, 32'h4,   1, 32'h4,   32'h8,   0);
        v[3]  = mk(0, 0, 0, 32'h0,   1, 32'h8,   0, 32'h4,   32'h8,   0);
        v[4]  = mk(0, 0, 0, 32'h0,   1, 32'h8,   0, 32'h4,   32'h8,   0);
        v[5]  = mk(0, 0, 0, 32'h0,   1, 32'h8,   0, 32'h4,   32'h8,   0);
        v[6]  = mk(1, 0, 0, 32'h0,   1, 32'h8,   1, 32'h8,   32'hC,   0);
        v[7]  = mk(1, 1, 0, 32'h0,   1, 32'hC,   1, 32'h8,   32'h10,  0);
        v[8]  = mk(1, 1, 0, 32'h0,   0, 32'h10,  1, 32'h8,   32'h10,  0);
        v[9]  = mk(1, 1, 0, 32'h0,   0, 32'h10,  1, 32'h8,   32'h10,  0);
        v[10] = mk(1, 1, 0, 32'h0,   0, 32'h10,  1, 32'h8,   32'h10,  0);
        v[11] = mk(1, 0, 0, 32'h0,   0, 32'h10,  1, 32'hC,   32'h10,  0);
        v[12] = mk(1, 0, 0, 32'h0,   1, 32'h10,  1, 32'h10,  32'h14,  0);
        v[13] = mk(0, 0, 1, 32'h100, 1, 32'h14,  0, 32'h10,  32'h100, 0);
        v[14] = mk(0, 0, 0, 32'h0,   1, 32'h14,  0, 32'h10,  32'h100, 0);
        v[15] = mk(1, 0, 0, 32'h0,   1, 32'h14,  0, 32'h10,  32'h100, 0);
        v[16] = mk(1, 0, 0, 32'h0,   1, 32'h100, 1, 32'h100, 32'h104, 0);
        v[17] = mk(1, 0, 0, 32'h0,   1, 32'h104, 1, 32'h104, 32'h108, 0);
        v[18] = mk(1, 1, 0, 32'h0,   1, 32'h108, 1, 32'h104, 32'h10C, 0);
        v[19] = mk(1, 1, 1, 32'h203, 0, 32'h10C, 0, 32'h104, 32'h200, 1);
        v[20] = mk(1, 0, 0, 32'h0,   1, 32'h200, 1, 32'h200, 32'h204, 0);
        v[21] = mk(1, 0, 0, 32'h0,   1, 32'h204, 1, 32'h204, 32'h208, 0);
        v[22] = mk(1, 0, 1, 32'h40,  1, 32'h208, 0, 32'h204, 32'h40,  0);
        v[23] = mk(1, 0, 0, 32'h0,   1, 32'h40,  1, 32'h40,  32'h44,  0);
        v[24] = mk(0, 0, 0, 32'h0,   1, 32'h44,  0, 32'h40,  32'h44,  0);
        v[25] = mk(0, 1, 0, 32'h0,   1, 32'h44,  0, 32'h40,  32'h44,  0);
        reset = 0; reset2 = 0; stall = 0; redir = 0; ready = 0; target = 0;
        redir2 = 0; ready2 = 0; target2 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, req}, 32'h0);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_mis", {31'h0, mis}, 32'h0);
        reset = 1;
        mon_en = 1;
        foreach (sb_init[i]) sb.push_back(sb_init[i]);
        for (int i = 0; i < 26; i++) begin
            #1;
            ready = v[i].ready; stall = v[i].stall; redir = v[i].redir; target = v[i].target;
            #1;
            chk($sformatf("v%0d_req", i), {31'h0, req}, {31'h0, v[i].req});
            chk($sformatf("v%0d_addr", i), addr, v[i].addr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'h0, if_valid}, {31'h0, v[i].valid});
            chk($sformatf("v%0d_if_pc", i), if_pc, v[i].ifpc);
            chk($sformatf("v%0d_pc", i), pc_out, v[i].pc);
            chk($sformatf("v%0d_mis", i), {31'h0, mis}, {31'h0, v[i].mis});
        end
        mon_en = 0;
        chk("sb_left", sb.size(), 32'd0);
        ready2 = 1; reset2 = 1;
        #2 chk("w_boot_req", {31'h0, req2}, 32'h0);
        @(posedge clk); #1;
        chk("w_req", {31'h0, req2}, 32'h1);
        chk("w_addr", addr2, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        chk("w_if0", if_pc2, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        chk("w_if1", if_pc2, 32'hFFFF_FFFC);
        chk("w_pc_wrap", pc2, 32'h0);
        @(posedge clk); #1;
        chk("w_if2", if_pc2, 32'h0);
        chk("w_instr2", if_instr2, K);
        chk("w_valid2", {31'h0, if_valid2}, 32'h1);
        ready2 = 0; redir2 = 1; target2 = 32'h80;
        @(posedge clk); #1;
        redir2 = 0;
        chk("w_drain_req", {31'h0, req2}, 32'h1);
        chk("w_drain_addr", addr2, 32'h4);
        chk("w_drain_pc", pc2, 32'h80);
        #2 reset2 = 0;
        #1;
        chk("w_rst_req", {31'h0, req2}, 32'h0);
        chk("w_rst_pc", pc2, 32'hFFFF_FFF8);
        chk("w_rst_valid", {31'h0, if_valid2}, 32'h0);
        chk("w_rst_instr", if_instr2, 32'h0000_0013);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    logic [31:0] sb_init[9] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100, 32'h200, 32'h204, 32'h40};
endmodule
